// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// sram_arbiter: round-robin arbiter and pin sequencer for the dual-port SRAM
// Revision: 1.0
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  nrst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [NUM_WMASKS-1:0] m0_wmask,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic                  m0_busy,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [NUM_WMASKS-1:0] m1_wmask,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  m1_busy,

    output logic                  sram_csb0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_ACK   = 2'd3;

    logic [1:0]                 req;
    logic [1:0]                 we;
    logic [1:0][ADDR_WIDTH-1:0] addr;
    logic [1:0][DATA_WIDTH-1:0] wdata;
    logic [1:0][NUM_WMASKS-1:0] wmask;

    assign req   = {m1_req, m0_req};
    assign we    = {m1_we, m0_we};
    assign addr  = {m1_addr, m0_addr};
    assign wdata = {m1_wdata, m0_wdata};
    assign wmask = {m1_wmask, m0_wmask};

    logic [1:0][1:0]            state_q, state_d;
    logic [1:0]                 we_q;
    logic [1:0][DATA_WIDTH-1:0] rdata_q;
    logic                       rr_q, rr_d;
    logic [1:0]                 cand;
    logic [1:0]                 gnt;

    logic                  csb0_q, csb0_d;
    logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic                  csb1_q, csb1_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;

    // The ACK cycle's req is the next transaction, so ACK counts as free;
    // this gives back-to-back grants every third cycle.
    always_comb begin
        cand = '0;
        for (int i = 0; i < 2; i++) begin
            cand[i] = req[i] && ((state_q[i] == S_IDLE) || (state_q[i] == S_ACK));
        end
        gnt  = cand;
        rr_d = rr_q;
        if (cand == 2'b11) begin
            if (we[0] != we[1]) begin
                if (addr[0] == addr[1]) begin
                    gnt = we;
                end
            end else begin
                gnt  = rr_q ? 2'b10 : 2'b01;
                rr_d = ~rr_q;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        for (int i = 0; i < 2; i++) begin
            case (state_q[i])
                S_IDLE:  state_d[i] = gnt[i] ? S_ISSUE : S_IDLE;
                S_ISSUE: state_d[i] = S_WAIT;
                S_WAIT:  state_d[i] = S_ACK;
                default: state_d[i] = gnt[i] ? S_ISSUE : S_IDLE;
            endcase
        end
    end

    always_comb begin
        csb0_d   = 1'b1;
        wmask0_d = '0;
        addr0_d  = '0;
        din0_d   = '0;
        csb1_d   = 1'b1;
        addr1_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (gnt[i] && we[i]) begin
                csb0_d   = 1'b0;
                wmask0_d = wmask[i];
                addr0_d  = addr[i];
                din0_d   = wdata[i];
            end
            if (gnt[i] && !we[i]) begin
                csb1_d  = 1'b0;
                addr1_d = addr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= {S_IDLE, S_IDLE};
            we_q     <= '0;
            rdata_q  <= '0;
            rr_q     <= 1'b0;
            csb0_q   <= 1'b1;
            wmask0_q <= '0;
            addr0_q  <= '0;
            din0_q   <= '0;
            csb1_q   <= 1'b1;
            addr1_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            csb0_q   <= csb0_d;
            wmask0_q <= wmask0_d;
            addr0_q  <= addr0_d;
            din0_q   <= din0_d;
            csb1_q   <= csb1_d;
            addr1_q  <= addr1_d;
            for (int i = 0; i < 2; i++) begin
                if (gnt[i]) begin
                    we_q[i] <= we[i];
                end
                if ((state_q[i] == S_WAIT) && !we_q[i]) begin
                    rdata_q[i] <= sram_dout1;
                end
            end
        end
    end

    assign m0_ack   = (state_q[0] == S_ACK);
    assign m1_ack   = (state_q[1] == S_ACK);
    assign m0_busy  = (state_q[0] != S_IDLE);
    assign m1_busy  = (state_q[1] != S_IDLE);
    assign m0_rdata = rdata_q[0];
    assign m1_rdata = rdata_q[1];

    assign sram_csb0   = csb0_q;
    assign sram_wmask0 = wmask0_q;
    assign sram_addr0  = addr0_q;
    assign sram_din0   = din0_q;
    assign sram_csb1   = csb1_q;
    assign sram_addr1  = addr1_q;

endmodule
`default_nettype wire
